// File: rtl/tracker_overlay_if.sv
// tracker_overlay_if: per-frame tracker results (aim points, boxes, valid flags, timeout) fed to the overlay
interface tracker_overlay_if;
    logic [15:0][9:0]  aim_x_all;
    logic [15:0][9:0]  aim_y_all;
    logic [15:0]       aim_detected_all;
    logic [15:0][11:0] x_min_all;
    logic [15:0][11:0] x_max_all;
    logic [15:0][11:0] y_min_all;
    logic [15:0][11:0] y_max_all;
    logic              target_off;

    modport master (
        output aim_x_all, aim_y_all, aim_detected_all,
        output x_min_all, x_max_all, y_min_all, y_max_all,
        output target_off
    );

    modport slave (
        input aim_x_all, aim_y_all, aim_detected_all,
        input x_min_all, x_max_all, y_min_all, y_max_all,
        input target_off
    );
endinterface

// File: rtl/tracker_overlay.sv
// tracker_overlay: draws tracker boxes, crosshairs and a blinking no-target border onto RGB565 video
// with a fixed two-cycle latency; tracker results are sampled once per frame.
module tracker_overlay #(
    parameter int CROSS_LEN    = 8,
    parameter int BORDER_W     = 4,
    parameter int BLINK_FRAMES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_sync,
    input  logic             DE,
    input  logic [9:0]       x_pixel,
    input  logic [9:0]       y_pixel,
    input  logic [15:0]      data,
    tracker_overlay_if.slave trk,
    output logic             DE_out,
    output logic [9:0]       x_out,
    output logic [9:0]       y_out,
    output logic [15:0]      rgb_out
);
    localparam int               CNT_W     = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(BLINK_FRAMES / 2);
    localparam logic [9:0]       EDGE_LO   = 10'(BORDER_W);
    localparam logic [9:0]       X_EDGE_HI = 10'(640 - BORDER_W);
    localparam logic [9:0]       Y_EDGE_HI = 10'(480 - BORDER_W);
    localparam logic [11:0]      CROSS_LIM = 12'(CROSS_LEN);
    localparam logic [15:0]      COL_CROSS  = 16'hFFE0;
    localparam logic [15:0]      COL_BOX    = 16'h07E0;
    localparam logic [15:0]      COL_BORDER = 16'hF800;

    // Frame-latch control and shadow copies of the tracker results
    logic                    vsyncPrev_q;
    logic                    latchPend_q;
    logic [15:0][9:0]        shAimX_q;
    logic [15:0][9:0]        shAimY_q;
    logic [15:0]             shDet_q;
    logic [15:0][11:0]       shXMin_q;
    logic [15:0][11:0]       shXMax_q;
    logic [15:0][11:0]       shYMin_q;
    logic [15:0][11:0]       shYMax_q;
    logic                    shTargetOff_q;
    logic [CNT_W-1:0]        blinkCnt_q;
    logic [CNT_W-1:0]        blinkCnt_d;

    // Stage 1 registers
    logic [15:0]             boxHit_d, boxHit_q;
    logic [15:0]             crossHit_d, crossHit_q;
    logic                    borderHit_d, borderHit_q;
    logic                    de1_q;
    logic [9:0]              x1_q, y1_q;
    logic [15:0]             data1_q;

    logic [11:0]             pxExt, pyExt;

    assign pxExt = {2'b00, x_pixel};
    assign pyExt = {2'b00, y_pixel};

    // Magnitude of a coordinate difference, computed signed so the crosshair never wraps at screen edges
    function automatic logic [11:0] absDiff(input logic [9:0] a, input logic [9:0] b);
        logic signed [11:0] d;
        d = $signed({2'b00, a}) - $signed({2'b00, b});
        return (d < 0) ? 12'(-d) : 12'(d);
    endfunction

    // Blink count: only keeps counting across consecutive frames that are both in timeout
    always_comb begin
        blinkCnt_d = '0;
        if (trk.target_off && shTargetOff_q) begin
            blinkCnt_d = (blinkCnt_q == CNT_LAST) ? '0 : blinkCnt_q + 1'b1;
        end
    end

    // Catch the v_sync rising edge and snapshot the tracker results one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsyncPrev_q   <= 1'b0;
            latchPend_q   <= 1'b0;
            shAimX_q      <= '0;
            shAimY_q      <= '0;
            shDet_q       <= '0;
            shXMin_q      <= '0;
            shXMax_q      <= '0;
            shYMin_q      <= '0;
            shYMax_q      <= '0;
            shTargetOff_q <= 1'b0;
            blinkCnt_q    <= '0;
        end else begin
            vsyncPrev_q <= v_sync;
            latchPend_q <= v_sync & ~vsyncPrev_q;
            if (latchPend_q) begin
                shAimX_q      <= trk.aim_x_all;
                shAimY_q      <= trk.aim_y_all;
                shDet_q       <= trk.aim_detected_all;
                shXMin_q      <= trk.x_min_all;
                shXMax_q      <= trk.x_max_all;
                shYMin_q      <= trk.y_min_all;
                shYMax_q      <= trk.y_max_all;
                shTargetOff_q <= trk.target_off;
                blinkCnt_q    <= blinkCnt_d;
            end
        end
    end

    // Per-region hit tests against the shadowed boxes and aim points for the current pixel
    always_comb begin
        boxHit_d   = '0;
        crossHit_d = '0;
        for (int i = 0; i < 16; i++) begin
            if (shDet_q[i]) begin
                if ((shXMin_q[i] <= shXMax_q[i]) && (shYMin_q[i] <= shYMax_q[i])) begin
                    if (((pxExt == shXMin_q[i]) || (pxExt == shXMax_q[i])) &&
                        (pyExt >= shYMin_q[i]) && (pyExt <= shYMax_q[i])) begin
                        boxHit_d[i] = 1'b1;
                    end
                    if (((pyExt == shYMin_q[i]) || (pyExt == shYMax_q[i])) &&
                        (pxExt >= shXMin_q[i]) && (pxExt <= shXMax_q[i])) begin
                        boxHit_d[i] = 1'b1;
                    end
                end
                if ((y_pixel == shAimY_q[i]) && (absDiff(x_pixel, shAimX_q[i]) <= CROSS_LIM)) begin
                    crossHit_d[i] = 1'b1;
                end
                if ((x_pixel == shAimX_q[i]) && (absDiff(y_pixel, shAimY_q[i]) <= CROSS_LIM)) begin
                    crossHit_d[i] = 1'b1;
                end
            end
        end
        borderHit_d = shTargetOff_q && (blinkCnt_q < CNT_HALF) &&
                      ((x_pixel < EDGE_LO) || (x_pixel >= X_EDGE_HI) ||
                       (y_pixel < EDGE_LO) || (y_pixel >= Y_EDGE_HI));
    end

    // Stage 1: register hit vectors alongside the delayed video
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            boxHit_q    <= '0;
            crossHit_q  <= '0;
            borderHit_q <= 1'b0;
            de1_q       <= 1'b0;
            x1_q        <= '0;
            y1_q        <= '0;
            data1_q     <= '0;
        end else begin
            boxHit_q    <= boxHit_d;
            crossHit_q  <= crossHit_d;
            borderHit_q <= borderHit_d;
            de1_q       <= DE;
            x1_q        <= x_pixel;
            y1_q        <= y_pixel;
            data1_q     <= data;
        end
    end

    // Stage 2: pick the overlay colour by priority and blank outside the active area
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            DE_out  <= 1'b0;
            x_out   <= '0;
            y_out   <= '0;
            rgb_out <= '0;
        end else begin
            DE_out <= de1_q;
            x_out  <= x1_q;
            y_out  <= y1_q;
            if (!de1_q) begin
                rgb_out <= 16'h0000;
            end else if (|crossHit_q) begin
                rgb_out <= COL_CROSS;
            end else if (|boxHit_q) begin
                rgb_out <= COL_BOX;
            end else if (borderHit_q) begin
                rgb_out <= COL_BORDER;
            end else begin
                rgb_out <= data1_q;
            end
        end
    end
endmodule

// File: tb/tb_tracker_overlay.sv
// tb_tracker_overlay: directed checks of the tracker overlay with hand-computed expected pixels
module tb_tracker_overlay;
    logic        clk = 1'b0;
    logic        reset;
    logic        v_sync;
    logic        DE;
    logic [9:0]  x_pixel, y_pixel;
    logic [15:0] data;
    logic        DE_out;
    logic [9:0]  x_out, y_out;
    logic [15:0] rgb_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    tracker_overlay_if trk();

    tracker_overlay dut (
        .clk     (clk),
        .reset   (reset),
        .v_sync  (v_sync),
        .DE      (DE),
        .x_pixel (x_pixel),
        .y_pixel (y_pixel),
        .data    (data),
        .trk     (trk),
        .DE_out  (DE_out),
        .x_out   (x_out),
        .y_out   (y_out),
        .rgb_out (rgb_out)
    );

    always #5 clk = ~clk;

    // Drive one pixel at a falling edge and sample the outputs two clocks later
    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic [15:0] d,
                                 input logic de, output logic [15:0] rgb, output logic deo,
                                 output logic [9:0] xo, output logic [9:0] yo);
        @(negedge clk);
        x_pixel = x;
        y_pixel = y;
        data    = d;
        DE      = de;
        @(negedge clk);
        @(negedge clk);
        rgb = rgb_out;
        deo = DE_out;
        xo  = x_out;
        yo  = y_out;
    endtask

    // Pulse v_sync so the DUT snapshots the current tracker inputs
    task automatic frameLatch();
        @(negedge clk);
        v_sync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        v_sync = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] rgb;
        logic deo;
        logic [9:0] xo, yo;
        @(negedge clk);
        DE = 1'b1; x_pixel = 10'd77; y_pixel = 10'd33; data = 16'hBEEF;
        repeat (3) @(negedge clk);
        checks++; if (DE_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_de DE_out=%b expected 0", DE_out); end
        checks++; if (x_out !== 10'd0) begin errors++; $display("[TB] FAIL reset_x x_out=%0d expected 0", x_out); end
        checks++; if (y_out !== 10'd0) begin errors++; $display("[TB] FAIL reset_y y_out=%0d expected 0", y_out); end
        checks++; if (rgb_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rgb rgb_out=%h expected 0000", rgb_out); end
        @(negedge clk);
        reset = 1'b1;
        trk.aim_detected_all[0] = 1'b1;
        trk.x_min_all[0] = 12'd10; trk.x_max_all[0] = 12'd50;
        trk.y_min_all[0] = 12'd20; trk.y_max_all[0] = 12'd60;
        applyStimulus(10'd10, 10'd40, 16'h1111, 1'b1, rgb, deo, xo, yo);
        checks++; if (rgb !== 16'h1111) begin errors++; $display("[TB] FAIL prelatch_rgb rgb_out=%h expected 1111", rgb); end
    endtask

    task automatic test_box();
        vec_t v[6];
        logic [15:0] rgb;
        logic deo;
        logic [9:0] xo, yo;
        frameLatch();
        v[0] = '{10'd10, 10'd40, 16'h1234, 16'h07E0};
        v[1] = '{10'd30, 10'd40, 16'h1234, 16'h1234};
        v[2] = '{10'd50, 10'd20, 16'h4321, 16'h07E0};
        v[3] = '{10'd30, 10'd60, 16'h4321, 16'h07E0};
        v[4] = '{10'd51, 10'd40, 16'h5555, 16'h5555};
        v[5] = '{10'd10, 10'd61, 16'h6666, 16'h6666};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(v[i].x, v[i].y, v[i].d, 1'b1, rgb, deo, xo, yo);
            checks++;
            if (rgb !== v[i].exp) begin errors++; $display("[TB] FAIL box[%0d] rgb_out=%h expected %h", i, rgb, v[i].exp); end
        end
        applyStimulus(10'd30, 10'd40, 16'h1234, 1'b1, rgb, deo, xo, yo);
        checks++; if (xo !== 10'd30 || yo !== 10'd40) begin errors++; $display("[TB] FAIL box_xy x_out=%0d y_out=%0d expected 30 40", xo, yo); end
        checks++; if (deo !== 1'b1) begin errors++; $display("[TB] FAIL box_de DE_out=%b expected 1", deo); end
    endtask

    task automatic test_cross();
        vec_t v[5];
        logic [15:0] rgb;
        logic deo;
        logic [9:0] xo, yo;
        trk.aim_detected_all[5] = 1'b1;
        trk.aim_x_all[5] = 10'd200; trk.aim_y_all[5] = 10'd150;
        trk.x_min_all[5] = 12'd0; trk.x_max_all[5] = 12'd0;
        trk.y_min_all[5] = 12'd900; trk.y_max_all[5] = 12'd900;
        frameLatch();
        v[0] = '{10'd208, 10'd150, 16'hA001, 16'hFFE0};
        v[1] = '{10'd200, 10'd142, 16'hA002, 16'hFFE0};
        v[2] = '{10'd209, 10'd150, 16'hA003, 16'hA003};
        v[3] = '{10'd200, 10'd159, 16'hA004, 16'hA004};
        v[4] = '{10'd201, 10'd151, 16'hA005, 16'hA005};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(v[i].x, v[i].y, v[i].d, 1'b1, rgb, deo, xo, yo);
            checks++;
            if (rgb !== v[i].exp) begin errors++; $display("[TB] FAIL cross[%0d] rgb_out=%h expected %h", i, rgb, v[i].exp); end
        end
    endtask

    task automatic test_edge_wrap();
        vec_t v[4];
        logic [15:0] rgb;
        logic deo;
        logic [9:0] xo, yo;
        trk.aim_detected_all[2] = 1'b1;
        trk.aim_x_all[2] = 10'd3; trk.aim_y_all[2] = 10'd300;
        trk.x_min_all[2] = 12'd5; trk.x_max_all[2] = 12'd1;
        frameLatch();
        v[0] = '{10'd0,    10'd300, 16'hB001, 16'hFFE0};
        v[1] = '{10'd11,   10'd300, 16'hB002, 16'hFFE0};
        v[2] = '{10'd12,   10'd300, 16'hB003, 16'hB003};
        v[3] = '{10'd1023, 10'd300, 16'hB004, 16'hB004};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(v[i].x, v[i].y, v[i].d, 1'b1, rgb, deo, xo, yo);
            checks++;
            if (rgb !== v[i].exp) begin errors++; $display("[TB] FAIL wrap[%0d] rgb_out=%h expected %h", i, rgb, v[i].exp); end
        end
    endtask

    task automatic test_priority();
        logic [15:0] rgb;
        logic deo;
        logic [9:0] xo, yo;
        trk.aim_detected_all[1] = 1'b1;
        trk.x_min_all[1] = 12'd150; trk.x_max_all[1] = 12'd208;
        trk.y_min_all[1] = 12'd100; trk.y_max_all[1] = 12'd200;
        trk.aim_x_all[1] = 10'd600; trk.aim_y_all[1] = 10'd400;
        frameLatch();
        applyStimulus(10'd208, 10'd150, 16'hC001, 1'b1, rgb, deo, xo, yo);
        checks++; if (rgb !== 16'hFFE0) begin errors++; $display("[TB] FAIL prio_cross_box rgb_out=%h expected FFE0", rgb); end
        applyStimulus(10'd208, 10'd100, 16'hC002, 1'b1, rgb, deo, xo, yo);
        checks++; if (rgb !== 16'h07E0) begin errors++; $display("[TB] FAIL prio_box_only rgb_out=%h expected 07E0", rgb); end
    endtask

    task automatic test_degenerate();
        vec_t v[5];
        logic [15:0] rgb;
        logic deo;
        logic [9:0] xo, yo;
        trk.aim_detected_all[3] = 1'b1;
        trk.x_min_all[3] = 12'd300; trk.x_max_all[3] = 12'd300;
        trk.y_min_all[3] = 12'd10;  trk.y_max_all[3] = 12'd20;
        trk.aim_x_all[3] = 10'd700; trk.aim_y_all[3] = 10'd700;
        trk.aim_detected_all[4] = 1'b1;
        trk.x_min_all[4] = 12'd400; trk.x_max_all[4] = 12'd390;
        trk.y_min_all[4] = 12'd10;  trk.y_max_all[4] = 12'd20;
        trk.aim_x_all[4] = 10'd700; trk.aim_y_all[4] = 10'd700;
        trk.aim_detected_all[7] = 1'b0;
        trk.x_min_all[7] = 12'd500; trk.x_max_all[7] = 12'd520;
        trk.y_min_all[7] = 12'd10;  trk.y_max_all[7] = 12'd20;
        trk.aim_x_all[7] = 10'd510; trk.aim_y_all[7] = 10'd15;
        frameLatch();
        v[0] = '{10'd300, 10'd15, 16'hD001, 16'h07E0};
        v[1] = '{10'd301, 10'd15, 16'hD002, 16'hD002};
        v[2] = '{10'd400, 10'd15, 16'hD003, 16'hD003};
        v[3] = '{10'd395, 10'd10, 16'hD004, 16'hD004};
        v[4] = '{10'd500, 10'd15, 16'hD005, 16'hD005};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(v[i].x, v[i].y, v[i].d, 1'b1, rgb, deo, xo, yo);
            checks++;
            if (rgb !== v[i].exp) begin errors++; $display("[TB] FAIL degen[%0d] rgb_out=%h expected %h", i, rgb, v[i].exp); end
        end
    endtask

    task automatic test_de_blank();
        logic [15:0] rgb;
        logic deo;
        logic [9:0] xo, yo;
        applyStimulus(10'd10, 10'd40, 16'hE001, 1'b0, rgb, deo, xo, yo);
        checks++; if (rgb !== 16'h0000) begin errors++; $display("[TB] FAIL blank_rgb rgb_out=%h expected 0000", rgb); end
        checks++; if (deo !== 1'b0) begin errors++; $display("[TB] FAIL blank_de DE_out=%b expected 0", deo); end
    endtask

    task automatic test_midframe();
        logic [15:0] rgb;
        logic deo;
        logic [9:0] xo, yo;
        trk.x_min_all[0] = 12'd100; trk.x_max_all[0] = 12'd150;
        applyStimulus(10'd10, 10'd40, 16'hF001, 1'b1, rgb, deo, xo, yo);
        checks++; if (rgb !== 16'h07E0) begin errors++; $display("[TB] FAIL mid_old_box rgb_out=%h expected 07E0", rgb); end
        applyStimulus(10'd100, 10'd40, 16'hF002, 1'b1, rgb, deo, xo, yo);
        checks++; if (rgb !== 16'hF002) begin errors++; $display("[TB] FAIL mid_new_hidden rgb_out=%h expected F002", rgb); end
        frameLatch();
        applyStimulus(10'd100, 10'd40, 16'hF003, 1'b1, rgb, deo, xo, yo);
        checks++; if (rgb !== 16'h07E0) begin errors++; $display("[TB] FAIL mid_new_box rgb_out=%h expected 07E0", rgb); end
        applyStimulus(10'd10, 10'd40, 16'hF004, 1'b1, rgb, deo, xo, yo);
        checks++; if (rgb !== 16'hF004) begin errors++; $display("[TB] FAIL mid_old_gone rgb_out=%h expected F004", rgb); end
    endtask

    task automatic test_blink();
        vec_t v[7];
        logic [15:0] rgb, exp;
        logic deo;
        logic [9:0] xo, yo;
        trk.aim_detected_all = '0;
        trk.target_off = 1'b1;
        frameLatch();
        v[0] = '{10'd0,   10'd0,   16'h2468, 16'hF800};
        v[1] = '{10'd3,   10'd100, 16'h2001, 16'hF800};
        v[2] = '{10'd4,   10'd100, 16'h2002, 16'h2002};
        v[3] = '{10'd635, 10'd100, 16'h2003, 16'h2003};
        v[4] = '{10'd636, 10'd100, 16'h2004, 16'hF800};
        v[5] = '{10'd100, 10'd475, 16'h2005, 16'h2005};
        v[6] = '{10'd100, 10'd476, 16'h2006, 16'hF800};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(v[i].x, v[i].y, v[i].d, 1'b1, rgb, deo, xo, yo);
            checks++;
            if (rgb !== v[i].exp) begin errors++; $display("[TB] FAIL border[%0d] rgb_out=%h expected %h", i, rgb, v[i].exp); end
        end
        for (int f = 2; f <= 17; f++) begin
            frameLatch();
            exp = (f <= 8 || f == 17) ? 16'hF800 : 16'h2468;
            applyStimulus(10'd0, 10'd0, 16'h2468, 1'b1, rgb, deo, xo, yo);
            checks++;
            if (rgb !== exp) begin errors++; $display("[TB] FAIL blink_frame%0d rgb_out=%h expected %h", f, rgb, exp); end
        end
        trk.target_off = 1'b0;
        frameLatch();
        applyStimulus(10'd0, 10'd0, 16'h3579, 1'b1, rgb, deo, xo, yo);
        checks++; if (rgb !== 16'h3579) begin errors++; $display("[TB] FAIL blink_off rgb_out=%h expected 3579", rgb); end
        trk.target_off = 1'b1;
        frameLatch();
        applyStimulus(10'd0, 10'd0, 16'h3579, 1'b1, rgb, deo, xo, yo);
        checks++; if (rgb !== 16'hF800) begin errors++; $display("[TB] FAIL blink_restart rgb_out=%h expected F800", rgb); end
        trk.target_off = 1'b0;
        frameLatch();
    endtask

    task automatic test_reset_midline();
        logic [15:0] rgb;
        logic deo;
        logic [9:0] xo, yo;
        trk.aim_detected_all[0] = 1'b1;
        frameLatch();
        applyStimulus(10'd100, 10'd40, 16'hABCD, 1'b1, rgb, deo, xo, yo);
        checks++; if (rgb !== 16'h07E0) begin errors++; $display("[TB] FAIL rst_before rgb_out=%h expected 07E0", rgb); end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (DE_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_de DE_out=%b expected 0", DE_out); end
        checks++; if (x_out !== 10'd0 || y_out !== 10'd0) begin errors++; $display("[TB] FAIL rst_mid_xy x_out=%0d y_out=%0d expected 0 0", x_out, y_out); end
        checks++; if (rgb_out !== 16'h0000) begin errors++; $display("[TB] FAIL rst_mid_rgb rgb_out=%h expected 0000", rgb_out); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (DE_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_rel_1cyc DE_out=%b expected 0", DE_out); end
        @(negedge clk);
        checks++; if (DE_out !== 1'b1) begin errors++; $display("[TB] FAIL rst_rel_2cyc DE_out=%b expected 1", DE_out); end
        checks++; if (rgb_out !== 16'hABCD) begin errors++; $display("[TB] FAIL rst_no_overlay rgb_out=%h expected ABCD", rgb_out); end
        frameLatch();
        applyStimulus(10'd100, 10'd40, 16'hABCD, 1'b1, rgb, deo, xo, yo);
        checks++; if (rgb !== 16'h07E0) begin errors++; $display("[TB] FAIL rst_relatch rgb_out=%h expected 07E0", rgb); end
    endtask

    initial begin
        reset = 1'b0;
        v_sync = 1'b0;
        DE = 1'b0;
        x_pixel = '0;
        y_pixel = '0;
        data = '0;
        trk.aim_x_all = '0;
        trk.aim_y_all = '0;
        trk.aim_detected_all = '0;
        trk.x_min_all = '0;
        trk.x_max_all = '0;
        trk.y_min_all = '0;
        trk.y_max_all = '0;
        trk.target_off = 1'b0;
        test_reset();
        test_box();
        test_cross();
        test_edge_wrap();
        test_priority();
        test_degenerate();
        test_de_blank();
        test_midframe();
        test_blink();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tracker_overlay.md
TRACKER_OVERLAY -- requirements
Module: tracker_overlay

Interface
REQ-001 Parameter CROSS_LEN, default 8: crosshair half-length in pixels.
REQ-002 Parameter BORDER_W, default 4: width in pixels of the no-target border.
REQ-003 Parameter BLINK_FRAMES, default 16, even: period in frames of the no-target border blink.
REQ-004 clk  input  1  pixel clock, the single clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 v_sync, DE  input  1 each  VGA timing, same meaning as at the tracker input.
REQ-007 x_pixel, y_pixel  input  10 each  current pixel coordinate.
REQ-008 data  input  16  camera pixel, RGB565.
REQ-009 aim_x_all, aim_y_all  input  16x10  per-region aim point from tracker.
REQ-010 aim_detected_all  input  16  per-region valid flag from tracker.
REQ-011 x_min_all, x_max_all, y_min_all, y_max_all  input  16x12 each  per-region bounding box.
REQ-012 target_off  input  1  tracker no-target timeout flag.
REQ-013 DE_out  output  1  DE delayed to align with rgb_out.
REQ-014 x_out, y_out  output  10 each  coordinates aligned with rgb_out.
REQ-015 rgb_out  output  16  RGB565 pixel with overlay applied.

Function
REQ-016 Frame latch: detect v_sync rising edge (v_sync high, previous-cycle v_sync low); one cycle after that edge, copy all tracker inputs (REQ-009..REQ-012) into shadow registers; drawing uses only shadow values.
REQ-017 Shadows hold constant between latches; tracker input changes mid-frame do not affect the current frame.
REQ-018 Pipeline: 2-cycle fixed latency; DE_out, x_out, y_out and the passthrough pixel are delayed exactly 2 cycles from DE, x_pixel, y_pixel and data.
REQ-019 Stage 1 registers a 16-bit box-hit vector, a 16-bit cross-hit vector and a border-hit bit; stage 2 selects the colour and registers the outputs.
REQ-020 Box hit for region i: shadow detected[i]=1 and pixel on the rectangle edge: (x==x_min or x==x_max) with y_min<=y<=y_max, or (y==y_min or y==y_max) with x_min<=x<=x_max; compare coordinates zero-extended to 12 bits.
REQ-021 Cross hit for region i: shadow detected[i]=1 and either (y==aim_y and |x-aim_x|<=CROSS_LEN) or (x==aim_x and |y-aim_y|<=CROSS_LEN); compute the difference in 12-bit signed arithmetic, with no wrap-around at screen edges (aim_x=3 covers x 0..11 only).
REQ-022 Border hit: shadow target_off=1, blink phase on, and x<BORDER_W or x>=640-BORDER_W or y<BORDER_W or y>=480-BORDER_W.
REQ-023 Blink counter: 0..BLINK_FRAMES-1, advances by 1 at each frame latch while shadow target_off=1, wraps to 0; cleared to 0 at any latch with target_off=0; phase on when count < BLINK_FRAMES/2.
REQ-024 Colour priority, highest first: cross hit -> 16'hFFE0; box hit -> 16'h07E0; border hit -> 16'hF800; otherwise delayed data.
REQ-025 When the delayed DE is 0, rgb_out = 16'h0000 regardless of hits.
REQ-026 Regions with shadow detected=0 never contribute hits, whatever their coordinate values.
REQ-027 Overlapping boxes or crosshairs from several regions draw the same colour; no per-region colouring.
REQ-028 A degenerate box (x_min==x_max, or y_min==y_max) draws a single line segment; a box with x_min>x_max draws nothing.

Reset
REQ-029 While reset=0: DE_out=0, x_out=0, y_out=0, rgb_out=0, all pipeline registers 0, shadow detected=0, shadow target_off=0, blink count=0, v_sync edge history=0.
REQ-030 Reset deassertion mid-frame: no overlay appears until the first frame latch after release; passthrough resumes within 2 cycles.

Verification
REQ-031 Box[0]=(10,20)-(50,60), detected[0]=1, latched; pixel (10,40) -> rgb_out=07E0; pixel (30,40) -> data passthrough, 2 cycles later.
REQ-032 aim[5]=(200,150), detected[5]=1; pixels (208,150) and (200,142) -> FFE0; pixel (209,150) -> passthrough.
REQ-033 Crosshair and box edge on the same pixel -> FFE0 (priority check).
REQ-034 target_off=1 held 16 frames: pixel (0,0) = F800 in frames 1-8 after first latch, passthrough in frames 9-16, F800 again in frame 17; drop target_off -> counter 0, no border.
REQ-035 Change box inputs mid-frame -> current-frame output unchanged; new box visible from next latch.
REQ-036 Assert reset mid-line -> all outputs 0 immediately; after release, DE_out follows DE with 2-cycle delay and no overlay until next latch.
